mem_stage: RTL and testbench

//  Memory stage directly downstream of the execute stage: consumes aluout (effective address or ALU

---
 rtl/mem_stage.sv | 117 +++++++++++
 tb/tb_mem_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32 memory stage: byte/half/word loads and stores on an internal data memory,
// with a one-cycle registered write-back result and a stall hold.
module mem_stage #(
  parameter int n     = 32,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         stall,
  input  logic [n-1:0] aluout,
  input  logic [n-1:0] rdata2,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [2:0]   funct3,
  input  logic         regwrite_in,
  input  logic [4:0]   rd_in,
  output logic         out_valid,
  output logic [n-1:0] wb_data,
  output logic [4:0]   wb_rd,
  output logic         wb_regwrite,
  output logic         mem_fault
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: in_valid qualifies the instruction on the inputs; stall=1 freezes every
  // register and the memory, and upstream must hold its inputs until stall drops.

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] idx;
  logic [n-1:0]  word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [n-1:0]  load_val;
  logic          load_ok, store_ok, misaligned, fault;
  logic          we;
  logic [3:0]    be;
  logic [n-1:0]  wdata;

  assign idx = aluout[AW+1:2];

  always_comb begin
    load_ok    = 1'b0;
    store_ok   = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      3'b000: begin load_ok = 1'b1; store_ok = 1'b1; end
      3'b001: begin load_ok = 1'b1; store_ok = 1'b1; misaligned = aluout[0]; end
      3'b010: begin load_ok = 1'b1; store_ok = 1'b1; misaligned = (aluout[1:0] != 2'b00); end
      3'b100: load_ok = 1'b1;
      3'b101: begin load_ok = 1'b1; misaligned = aluout[0]; end
      default: ;
    endcase
    fault = in_valid && (memread || memwrite) &&
            ((memread && memwrite) || (memwrite && !store_ok) ||
             (memread && !load_ok) || misaligned);
  end

  // Load path reads the array combinationally, so it sees memory before this edge's store.
  always_comb begin
    word     = mem[idx];
    byte_sel = word[8*aluout[1:0] +: 8];
    half_sel = aluout[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = word;
    endcase
  end

  always_comb begin
    we = rst_n && in_valid && memwrite && !stall && !fault;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << aluout[1:0];
        wdata = {4{rdata2[7:0]}};
      end
      2'b01: begin
        be    = aluout[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rdata2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rdata2;
      end
    endcase
  end

  // Memory array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (be[lane]) mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      mem_fault   <= 1'b0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      wb_rd       <= rd_in;
      mem_fault   <= fault;
      wb_regwrite <= in_valid && regwrite_in && !memwrite && !fault && (rd_in != 5'd0);
      wb_data     <= (in_valid && memread && !fault) ? load_val : aluout;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores, faults, stall hold, rd=0, async reset, aliasing.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, memread, memwrite, regwrite_in;
  logic [31:0] aluout, rdata2;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        out_valid, wb_regwrite, mem_fault;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.n(32), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .aluout(aluout), .rdata2(rdata2), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .regwrite_in(regwrite_in), .rd_in(rd_in),
    .out_valid(out_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .mem_fault(mem_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic mr, input logic mw, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic rw, input logic [4:0] rd);
    in_valid = v; memread = mr; memwrite = mw; stall = st; funct3 = f3;
    aluout = a; rdata2 = d; regwrite_in = rw; rd_in = rd;
  endtask

  // Present one instruction, then sample #1 after the edge that registers it.
  task automatic op(input logic v, input logic mr, input logic mw, input logic st,
                    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                    input logic rw, input logic [4:0] rd);
    set_in(v, mr, mw, st, f3, a, d, rw, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  wb_data, 32'd0);
    chk({tag, "_rd"},    32'(wb_rd), 32'd0);
    chk({tag, "_rw"},    32'(wb_regwrite), 32'd0);
    chk({tag, "_fault"}, 32'(mem_fault), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 5'd0);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then load
    op(1, 0, 1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 0, 5'd0);
    chk("sw_valid", 32'(out_valid), 32'd1);
    chk("sw_data", wb_data, 32'h10);
    chk("sw_rw", 32'(wb_regwrite), 32'd0);
    chk("sw_fault", 32'(mem_fault), 32'd0);
    op(1, 1, 0, 0, 3'b010, 32'h10, 32'h0, 1, 5'd5);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_rd", 32'(wb_rd), 32'd5);
    chk("lw_rw", 32'(wb_regwrite), 32'd1);

    // Byte store into lane 3, sign/zero extended reads
    op(1, 0, 1, 0, 3'b000, 32'h13, 32'h00000080, 0, 5'd0);
    op(1, 1, 0, 0, 3'b000, 32'h13, 32'h0, 1, 5'd6);
    chk("lb", wb_data, 32'hFFFFFF80);
    op(1, 1, 0, 0, 3'b100, 32'h13, 32'h0, 1, 5'd6);
    chk("lbu", wb_data, 32'h00000080);
    op(1, 1, 0, 0, 3'b010, 32'h10, 32'h0, 1, 5'd6);
    chk("lw_after_sb", wb_data, 32'h80ADBEEF);
    op(1, 1, 0, 0, 3'b001, 32'h12, 32'h0, 1, 5'd6);
    chk("lh_hi", wb_data, 32'hFFFF80AD);
    op(1, 1, 0, 0, 3'b101, 32'h10, 32'h0, 1, 5'd6);
    chk("lhu_lo", wb_data, 32'h0000BEEF);
    op(1, 0, 1, 0, 3'b001, 32'h16, 32'h0000A5C3, 0, 5'd0);
    op(1, 1, 0, 0, 3'b101, 32'h16, 32'h0, 1, 5'd6);
    chk("sh_hi_lhu", wb_data, 32'h0000A5C3);

    // Faults
    op(1, 1, 0, 0, 3'b001, 32'h11, 32'h0, 1, 5'd8);
    chk("lh_mis_fault", 32'(mem_fault), 32'd1);
    chk("lh_mis_rw", 32'(wb_regwrite), 32'd0);
    chk("lh_mis_data", wb_data, 32'h11);
    op(1, 0, 1, 0, 3'b010, 32'h12, 32'h11111111, 0, 5'd0);
    chk("sw_mis_fault", 32'(mem_fault), 32'd1);
    op(1, 0, 1, 0, 3'b100, 32'h10, 32'h22222222, 0, 5'd0);
    chk("sbu_illegal_fault", 32'(mem_fault), 32'd1);
    op(1, 1, 1, 0, 3'b010, 32'h10, 32'h33333333, 1, 5'd8);
    chk("rd_wr_fault", 32'(mem_fault), 32'd1);
    op(1, 1, 0, 0, 3'b110, 32'h10, 32'h0, 1, 5'd8);
    chk("ld_illegal_fault", 32'(mem_fault), 32'd1);
    op(1, 1, 0, 0, 3'b010, 32'h10, 32'h0, 1, 5'd5);
    chk("fault_readback", wb_data, 32'h80ADBEEF);
    chk("fault_cleared", 32'(mem_fault), 32'd0);

    // Stalled store: outputs frozen, written when stall drops
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 1, 1, 3'b010, 32'h20, 32'h12345678, 0, 5'd0);
      chk("stall_data", wb_data, 32'h80ADBEEF);
      chk("stall_rw", 32'(wb_regwrite), 32'd1);
    end
    op(1, 0, 1, 0, 3'b010, 32'h20, 32'h12345678, 0, 5'd0);
    chk("unstall_data", wb_data, 32'h20);
    chk("unstall_rw", 32'(wb_regwrite), 32'd0);
    op(1, 0, 1, 0, 3'b010, 32'h24, 32'h0, 0, 5'd0);
    op(1, 0, 1, 1, 3'b010, 32'h24, 32'h11111111, 0, 5'd0);
    op(0, 0, 1, 0, 3'b010, 32'h24, 32'h11111111, 1, 5'd9);
    chk("invalid_valid", 32'(out_valid), 32'd0);
    chk("invalid_rw", 32'(wb_regwrite), 32'd0);
    op(1, 1, 0, 0, 3'b010, 32'h24, 32'h0, 1, 5'd9);
    chk("withdrawn_store", wb_data, 32'h0);
    op(1, 1, 0, 0, 3'b010, 32'h20, 32'h0, 1, 5'd9);
    chk("lw_stalled_store", wb_data, 32'h12345678);

    // ALU pass-through, rd=0 suppression
    op(1, 0, 0, 0, 3'b000, 32'h55, 32'h0, 1, 5'd0);
    chk("alu_data", wb_data, 32'h55);
    chk("alu_rd0_rw", 32'(wb_regwrite), 32'd0);
    op(1, 0, 0, 0, 3'b000, 32'h55, 32'h0, 1, 5'd7);
    chk("alu_rd7_rw", 32'(wb_regwrite), 32'd1);
    chk("alu_rd7_rd", 32'(wb_rd), 32'd7);

    // Aliasing and async reset mid-stream
    op(1, 0, 1, 0, 3'b010, 32'h30, 32'h0, 0, 5'd0);
    op(1, 0, 1, 0, 3'b010, 32'h400, 32'hCAFEF00D, 0, 5'd0);
    set_in(1, 0, 1, 0, 3'b010, 32'h30, 32'h00000005, 0, 5'd0);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    op(1, 1, 0, 0, 3'b010, 32'h30, 32'h0, 1, 5'd3);
    chk("rst_drop_store", wb_data, 32'h0);
    op(1, 1, 0, 0, 3'b010, 32'h000, 32'h0, 1, 5'd3);
    chk("alias_lw0", wb_data, 32'hCAFEF00D);
    op(1, 1, 0, 0, 3'b010, 32'h7FC, 32'h0, 1, 5'd3);
    chk("alias_unwritten_lw", 32'(wb_rd), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
